// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan decoder.
// Glyph patterns are in gfedcba order (bit0 = segment a), active-high.
package seg7_pkg;

  // Segment bit positions inside the shared segment byte.
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Hex glyphs as produced by the converter bank.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

  // Frame reassembly states.
  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    CAPTURE    = 2'd1,
    COMMIT     = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational glyph-to-hex decoder.
//   pat_i   : 7-bit segment pattern, gfedcba
//   valid_o : 1 when pat_i is one of the 16 hex glyphs
//   digit_o : decoded hex digit, 0 when the pattern is not a glyph
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic       valid_o,
  output logic [3:0] digit_o
);

  // NOTE: every output gets a default before the case, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    valid_o = 1'b1;
    digit_o = 4'h0;
    case (pat_i)
      GLYPH_0: digit_o = 4'h0;
      GLYPH_1: digit_o = 4'h1;
      GLYPH_2: digit_o = 4'h2;
      GLYPH_3: digit_o = 4'h3;
      GLYPH_4: digit_o = 4'h4;
      GLYPH_5: digit_o = 4'h5;
      GLYPH_6: digit_o = 4'h6;
      GLYPH_7: digit_o = 4'h7;
      GLYPH_8: digit_o = 4'h8;
      GLYPH_9: digit_o = 4'h9;
      GLYPH_A: digit_o = 4'hA;
      GLYPH_B: digit_o = 4'hB;
      GLYPH_C: digit_o = 4'hC;
      GLYPH_D: digit_o = 4'hD;
      GLYPH_E: digit_o = 4'hE;
      GLYPH_F: digit_o = 4'hF;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Monitor for a time-multiplexed 7-segment display bus.
//   clk, rst    : clock, synchronous active-high reset
//   seg_in      : shared segment byte (bit0=a .. bit6=g, bit7=dp)
//   an_in       : one-hot digit enables, all-zero = blanking gap
//   numar       : reassembled hex value, digit i at [4i+3:4i]
//   dp_out      : decimal point per digit
//   frame_valid : one-cycle pulse when numar/dp_out/pat_err update
//   pat_err     : per digit, last committed frame held a non-glyph pattern
//   seq_err     : one-cycle pulse when a frame is aborted
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int N_DIG      = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           seg_in,
  input  logic [N_DIG-1:0]     an_in,
  output logic [4*N_DIG-1:0]   numar,
  output logic [N_DIG-1:0]     dp_out,
  output logic                 frame_valid,
  output logic [N_DIG-1:0]     pat_err,
  output logic                 seq_err
);

  localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  logic [7:0]         seg_q, seg_d;
  logic [N_DIG-1:0]   an_q, an_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fired_q, fired_d;
  state_e             state_q, state_d;
  logic [IDX_W-1:0]   exp_q, exp_d;
  logic [4*N_DIG-1:0] shadow_dig_q, shadow_dig_d;
  logic [N_DIG-1:0]   shadow_dp_q, shadow_dp_d;
  logic [N_DIG-1:0]   shadow_err_q, shadow_err_d;
  logic [4*N_DIG-1:0] numar_q, numar_d;
  logic [N_DIG-1:0]   dp_q, dp_d;
  logic [N_DIG-1:0]   pat_err_q, pat_err_d;
  logic               frame_valid_q, frame_valid_d;
  logic               seq_err_q, seq_err_d;

  logic               at_stable, stable_ev, one_hot, capture, multi_hot, store;
  logic [IDX_W-1:0]   cap_idx;
  logic               glyph_valid;
  logic [3:0]         glyph_dig;

  seg7_glyph_decode u_glyph (
    .pat_i   (seg_q[SEG_G:SEG_A]),
    .valid_o (glyph_valid),
    .digit_o (glyph_dig)
  );

  // Stability filter and capture strobe.
  always_comb begin
    seg_d = seg_in;
    an_d  = an_in;
    // The counter restarts on the same edge the new enable lands in an_q,
    // so cnt_q counts how many cycles an_q has held its current value.
    if (an_in != an_q)
      cnt_d = CNT_W'(1);
    else if (cnt_q == CNT_W'(STABLE_CYC))
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + CNT_W'(1);

    at_stable = (cnt_q == CNT_W'(STABLE_CYC));
    // fired_q limits the saturated counter to a single event per interval.
    fired_d   = (an_in != an_q) ? 1'b0 : (fired_q | at_stable);
    stable_ev = at_stable && !fired_q && (an_q != '0);
    one_hot   = ((an_q & (an_q - 1'b1)) == '0);
    capture   = stable_ev && one_hot;
    multi_hot = stable_ev && !one_hot;

    cap_idx = '0;
    for (int i = 0; i < N_DIG; i++)
      if (an_q[i]) cap_idx = IDX_W'(i);
  end

  // Frame reassembly.
  always_comb begin
    state_d       = state_q;
    exp_d         = exp_q;
    shadow_dig_d  = shadow_dig_q;
    shadow_dp_d   = shadow_dp_q;
    shadow_err_d  = shadow_err_q;
    numar_d       = numar_q;
    dp_d          = dp_q;
    pat_err_d     = pat_err_q;
    frame_valid_d = 1'b0;
    seq_err_d     = 1'b0;
    store         = 1'b0;

    case (state_q)
      // COMMIT publishes the shadow and otherwise behaves like WAIT_START.
      WAIT_START, COMMIT: begin
        if (state_q == COMMIT) begin
          numar_d       = shadow_dig_q;
          dp_d          = shadow_dp_q;
          pat_err_d     = shadow_err_q;
          frame_valid_d = 1'b1;
          state_d       = WAIT_START;
        end
        if (capture && cap_idx == '0) begin
          store   = 1'b1;
          exp_d   = IDX_W'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (capture) begin
          if (cap_idx == exp_q) begin
            store = 1'b1;
            if (exp_q == IDX_W'(N_DIG - 1))
              state_d = COMMIT;
            else
              exp_d = exp_q + IDX_W'(1);
          end else if (cap_idx == '0) begin
            store = 1'b1;
            exp_d = IDX_W'(1);
          end else begin
            seq_err_d = 1'b1;
            state_d   = WAIT_START;
          end
        end else if (multi_hot) begin
          seq_err_d = 1'b1;
          state_d   = WAIT_START;
        end
      end
      default: state_d = WAIT_START;
    endcase

    // A discarded frame needs no clearing: a commit is only reachable after
    // every digit has been rewritten in order.
    if (store) begin
      shadow_dig_d[{cap_idx, 2'b00} +: 4] = glyph_dig;
      shadow_dp_d[cap_idx]                = seg_q[SEG_DP];
      shadow_err_d[cap_idx]               = !glyph_valid;
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q         <= '0;
      an_q          <= '0;
      cnt_q         <= '0;
      fired_q       <= 1'b0;
      state_q       <= WAIT_START;
      exp_q         <= '0;
      // NOTE: the shadow buffer is reset explicitly because a reset must
      // leave no trace of an aborted frame.
      shadow_dig_q  <= '0;
      shadow_dp_q   <= '0;
      shadow_err_q  <= '0;
      numar_q       <= '0;
      dp_q          <= '0;
      pat_err_q     <= '0;
      frame_valid_q <= 1'b0;
      seq_err_q     <= 1'b0;
    end else begin
      seg_q         <= seg_d;
      an_q          <= an_d;
      cnt_q         <= cnt_d;
      fired_q       <= fired_d;
      state_q       <= state_d;
      exp_q         <= exp_d;
      shadow_dig_q  <= shadow_dig_d;
      shadow_dp_q   <= shadow_dp_d;
      shadow_err_q  <= shadow_err_d;
      numar_q       <= numar_d;
      dp_q          <= dp_d;
      pat_err_q     <= pat_err_d;
      frame_valid_q <= frame_valid_d;
      seq_err_q     <= seq_err_d;
    end
  end

  assign numar       = numar_q;
  assign dp_out      = dp_q;
  assign pat_err     = pat_err_q;
  assign frame_valid = frame_valid_q;
  assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder with an event-level reference model.
module tb_seg7_scan_decoder;

  localparam int N_DIG      = 4;
  localparam int STABLE_CYC = 4;
  localparam int CNT_W      = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  seg_in = '0;
  logic [3:0]  an_in  = '0;
  logic [15:0] numar;
  logic [3:0]  dp_out;
  logic        frame_valid;
  logic [3:0]  pat_err;
  logic        seq_err;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .N_DIG      (N_DIG),
    .STABLE_CYC (STABLE_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .an_in       (an_in),
    .numar       (numar),
    .dp_out      (dp_out),
    .frame_valid (frame_valid),
    .pat_err     (pat_err),
    .seq_err     (seq_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int fv_seen = 0;
  int seq_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [15:0] m_numar = '0;
  logic [3:0]  m_dp = '0, m_err = '0;
  logic        m_fv = 1'b0, m_seq = 1'b0;
  logic [3:0]  prev_an = '0;
  int          run = 0;
  bit          in_frame = 0;
  int          nxt = 0;
  logic [15:0] f_dig = '0, pend_numar = '0;
  logic [3:0]  f_dp = '0, f_err = '0, pend_dp = '0, pend_err = '0;
  int          commit_t = 0, seq_t = 0;

  task automatic put_digit(input int idx, input logic [7:0] s);
    logic [3:0] v;
    bit         ok;
    v  = 4'h0;
    ok = 0;
    for (int k = 0; k < 16; k++)
      if (glyph_tab[k] == s[6:0]) begin
        v  = 4'(k);
        ok = 1;
      end
    f_dig[4*idx +: 4] = v;
    f_dp[idx]         = s[7];
    f_err[idx]        = !ok;
  endtask

  // One stable enable interval has been seen: apply the frame rules.
  task automatic handle_event(input logic [3:0] an, input logic [7:0] s);
    int idx;
    if ($countones(an) != 1) begin
      if (in_frame) begin
        seq_t    = 1;
        in_frame = 0;
      end
      return;
    end
    idx = 0;
    for (int k = 0; k < N_DIG; k++)
      if (an[k]) idx = k;
    if (in_frame && idx == nxt) begin
      put_digit(idx, s);
      nxt++;
      if (nxt == N_DIG) begin
        pend_numar = f_dig;
        pend_dp    = f_dp;
        pend_err   = f_err;
        commit_t   = 2;
        in_frame   = 0;
      end
    end else if (idx == 0) begin
      put_digit(0, s);
      in_frame = 1;
      nxt      = 1;
    end else if (in_frame) begin
      seq_t    = 1;
      in_frame = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_numar  = '0;
      m_dp     = '0;
      m_err    = '0;
      m_fv     = 1'b0;
      m_seq    = 1'b0;
      prev_an  = '0;
      run      = 0;
      in_frame = 0;
      commit_t = 0;
      seq_t    = 0;
      return;
    end
    m_fv  = 1'b0;
    m_seq = 1'b0;
    if (seq_t > 0) begin
      seq_t--;
      if (seq_t == 0) m_seq = 1'b1;
    end
    if (commit_t > 0) begin
      commit_t--;
      if (commit_t == 0) begin
        m_numar = pend_numar;
        m_dp    = pend_dp;
        m_err   = pend_err;
        m_fv    = 1'b1;
      end
    end
    if (an_in == prev_an) begin
      if (run < 1000) run++;
    end else begin
      run = 1;
    end
    prev_an = an_in;
    if (run == STABLE_CYC && an_in != '0) handle_event(an_in, seg_in);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    check("numar", 32'(numar), 32'(m_numar));
    check("dp_out", 32'(dp_out), 32'(m_dp));
    check("pat_err", 32'(pat_err), 32'(m_err));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("seq_err", 32'(seq_err), 32'(m_seq));
    if (frame_valid === 1'b1) fv_seen++;
    if (seq_err === 1'b1) seq_seen++;
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [3:0] an, input logic [7:0] s, input int n);
    an_in  = an;
    seg_in = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3, input int gap);
    logic [7:0] s [4];
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    for (int i = 0; i < 4; i++) begin
      drive(4'(1 << i), s[i], 8);
      if (gap > 0) drive(4'h0, 8'h00, gap);
    end
    drive(4'h0, 8'h00, 4);
  endtask

  initial begin
    int seq0, fv0;
    repeat (3) @(negedge clk);
    check("rst_numar", 32'(numar), 32'h0);
    check("rst_dp", 32'(dp_out), 32'h0);
    check("rst_pat", 32'(pat_err), 32'h0);
    check("rst_fv", 32'(frame_valid), 32'h0);
    check("rst_seq", 32'(seq_err), 32'h0);
    rst = 1'b0;
    drive(4'h0, 8'h00, 3);

    // Clean scan with frame_valid timing on the last digit.
    drive(4'h1, 8'h06, 8);
    drive(4'h2, 8'h5B, 8);
    drive(4'h4, 8'h4F, 8);
    an_in  = 4'h8;
    seg_in = 8'h66;
    repeat (5) @(negedge clk);
    check("fv_at_5", 32'(frame_valid), 32'h0);
    @(negedge clk);
    check("fv_at_6", 32'(frame_valid), 32'h1);
    check("clean_numar", 32'(numar), 32'h4321);
    check("clean_dp", 32'(dp_out), 32'h0);
    check("clean_pat", 32'(pat_err), 32'h0);
    @(negedge clk);
    check("fv_at_7", 32'(frame_valid), 32'h0);
    drive(4'h8, 8'h66, 1);
    drive(4'h0, 8'h00, 4);

    // Multi-hot while idle is ignored.
    seq0 = seq_seen;
    drive(4'h6, 8'h7F, 8);
    drive(4'h0, 8'h00, 3);
    check("multi_idle_seq", 32'(seq_seen - seq0), 32'h0);

    // Hex glyphs and decimal point.
    scan(8'hF1, 8'h77, 8'h7C, 8'h39, 0);
    check("hex_numar", 32'(numar), 32'hCBAF);
    check("hex_dp", 32'(dp_out), 32'h1);

    // Glitch filter with blanking gaps.
    seq0 = seq_seen;
    drive(4'h1, 8'h06, 8);
    drive(4'h0, 8'h00, 3);
    drive(4'h2, 8'h5B, 2);
    drive(4'h0, 8'h00, 3);
    drive(4'h2, 8'h5B, 8);
    drive(4'h0, 8'h00, 3);
    drive(4'h4, 8'h4F, 8);
    drive(4'h0, 8'h00, 3);
    drive(4'h8, 8'h66, 8);
    drive(4'h0, 8'h00, 4);
    check("glitch_numar", 32'(numar), 32'h4321);
    check("glitch_seq", 32'(seq_seen - seq0), 32'h0);

    // Out-of-order digit aborts the frame.
    seq0 = seq_seen;
    fv0  = fv_seen;
    drive(4'h1, 8'h3F, 8);
    drive(4'h2, 8'h06, 8);
    drive(4'h8, 8'h4F, 8);
    drive(4'h0, 8'h00, 4);
    check("seqerr_pulses", 32'(seq_seen - seq0), 32'h1);
    check("seqerr_no_fv", 32'(fv_seen - fv0), 32'h0);
    check("seqerr_hold", 32'(numar), 32'h4321);
    scan(8'h3F, 8'h06, 8'h5B, 8'h4F, 0);
    check("after_seq_numar", 32'(numar), 32'h3210);

    // Multi-hot inside a frame aborts it.
    seq0 = seq_seen;
    drive(4'h1, 8'h06, 8);
    drive(4'h3, 8'h06, 8);
    drive(4'h0, 8'h00, 4);
    check("multi_frame_seq", 32'(seq_seen - seq0), 32'h1);
    check("multi_frame_hold", 32'(numar), 32'h3210);

    // Non-glyph pattern on digit 2.
    scan(8'h06, 8'h5B, 8'h00, 8'h66, 2);
    check("bad_numar", 32'(numar), 32'h4021);
    check("bad_pat", 32'(pat_err), 32'h4);

    // Reset in the middle of a frame.
    drive(4'h1, 8'h3F, 8);
    drive(4'h2, 8'h7F, 8);
    drive(4'h4, 8'h7F, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_numar", 32'(numar), 32'h0);
    check("midrst_pat", 32'(pat_err), 32'h0);
    check("midrst_dp", 32'(dp_out), 32'h0);
    drive(4'h0, 8'h00, 4);
    scan(8'h06, 8'h5B, 8'h4F, 8'h66, 0);
    check("postrst_numar", 32'(numar), 32'h4321);
    check("postrst_pat", 32'(pat_err), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the BCD/hex-to-7-segment converter bank.
- Samples a time-multiplexed 7-segment display bus: one shared segment byte plus one-hot digit enables.
- Rebuilds the N_DIG-digit hex value and the decimal-point pattern, and reports framing and pattern errors.
- Used as a display-bus monitor and in loop-back checks against the converter output.

Parameters:
- N_DIG, 4: number of digits on the scanned display.
- STABLE_CYC, 4: consecutive cycles an enable must hold before its digit is captured (glitch filter), >=2.
- CNT_W, 8: width of the stability counter; must hold STABLE_CYC.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- seg_in  input  8  segment byte: bit0=a … bit6=g, bit7=dp, active-high
- an_in  input  N_DIG  digit enable, one-hot active-high; all-zero = blanking gap
- numar  output  4*N_DIG  decoded value; digit i at [4i+3:4i]
- dp_out  output  N_DIG  captured dp bit per digit
- frame_valid  output  1  one-cycle pulse when numar/dp_out/pat_err update
- pat_err  output  N_DIG  per-digit flag: last committed frame held a non-glyph pattern
- seq_err  output  1  one-cycle pulse on frame abort

Behaviour:
- Reset: all outputs 0; FSM to WAIT_START; stability counter 0; shadow buffer cleared.
- Input stage: seg_in and an_in registered once (seg_r, an_r). All logic below uses the registered values.
- Stability counter:
  - Resets to 1 when an_r changes; otherwise increments, saturating at STABLE_CYC.
  - Exactly one capture event per enable interval: on the cycle the counter reaches STABLE_CYC with an_r nonzero and one-hot.
  - The capture stores seg_r from that cycle.
- Glyph decode, hex, gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - Any other 7-bit value decodes to 0 and sets that digit's shadow error bit.
  - dp (bit7) is captured independently of the glyph.
- FSM:
  - WAIT_START: ignores all captures except digit 0. A digit-0 capture stores digit 0 into the shadow buffer, sets expected index = 1, and moves to CAPTURE.
  - CAPTURE: a capture on the expected index stores that digit and increments the index.
    - Capture on the last digit (N_DIG-1) moves to COMMIT.
    - Capture on digit 0 restarts the frame: no error, shadow restarted with digit 0.
    - Capture on any other index: seq_err pulse, go to WAIT_START, shadow discarded.
  - COMMIT, one cycle: numar, dp_out and pat_err are loaded from the shadow and frame_valid pulses; return to WAIT_START.
    - A capture landing in this cycle is evaluated as if in WAIT_START.
- Multi-hot an_r held for STABLE_CYC cycles: in CAPTURE, seq_err pulse and return to WAIT_START; in WAIT_START, ignored.
- Blanking (an_r = 0) between digits is legal at any length and does not abort a frame.
- Latency: the last digit's capture occurs STABLE_CYC cycles after its an_in change. numar updates and frame_valid rises on the following clock, i.e. STABLE_CYC+2 clocks after the an_in edge, counting the input register.
- Outputs hold their last committed frame until the next commit; no partial updates.
- rst mid-frame: shadow discarded, outputs cleared in the same edge, no pulse emitted.

Decomposition:
- Package seg7_pkg:
  - glyph constants (GLYPH_0…GLYPH_F)
  - segment bit indices (SEG_A…SEG_DP)
  - FSM state enum {WAIT_START, CAPTURE, COMMIT}
- One sub-module, seg7_glyph_decode: combinational, 7-bit pattern -> {valid, 4-bit digit}. Instantiated once, since only one digit is captured per cycle.
- Top level holds the input registers, stability counter, FSM and shadow buffer.

Test Plan:
- Clean scan, N_DIG=4, STABLE_CYC=4, 8 cycles per enable, seg 06,5B,4F,66 on an 0001,0010,0100,1000 -> numar=16'h4321, dp_out=0, pat_err=0. frame_valid is a single pulse exactly 6 clocks after the an=1000 edge.
- Hex and dp: seg F1 (dp+F), 77, 7C, 39 -> numar=16'hCBAF, dp_out=4'b0001.
- Glitch filter: an=0010 held 2 cycles, then 0, inside an otherwise clean frame 1,2,3,4 with 3-cycle blank gaps -> numar=16'h4321, no seq_err.
- Sequence error: digits 0,1,3 -> seq_err single pulse on the digit-3 capture, no frame_valid, numar keeps its previous value. A following clean frame commits normally.
- Bad pattern: digit 2 driven 00 (blank glyph) -> frame commits, numar[11:8]=0, pat_err=4'b0100.
- Reset mid-frame: rst high for 1 cycle after digit 1 captured -> all outputs 0. The next full frame commits 16'h4321, with no stale digit from the aborted frame.
